sort6_stream: RTL and testbench

Streaming 6-entry byte sorter. It accepts a burst of N unsigned words over a valid/ready input port and stores them in an insertion-sorted register array, one word per cycle. It then emits the burst in descending order over a valid/ready output port, one word per cycle. It sits between a serial byte producer and the downstream consumer, as the serial-in/serial-out counterpart of the parallel 6-way combinational sorter, whose largest-first output order it matches.

---
 rtl/sort_pkg.sv | 11 +
 rtl/sort_cell.sv | 45 ++++
 rtl/sort6_stream.sv | 90 +++++++++
 tb/tb_sort6_stream.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sizing and state encoding for the streaming sorter
package sort_pkg;
  localparam int SORT_N = 6;
  localparam int SORT_W = 8;
  localparam int CNT_W  = $clog2(SORT_N + 1);

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/sort_cell.sv
// rtl/sort_cell.sv - one sorted slot: masked >= compare and hold/insert/shift mux
module sort_cell #(
  parameter int W   = 8,
  parameter int CW  = 3,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          ge_up_i,
  input  logic [W-1:0]  up_val_i,
  input  logic [W-1:0]  dn_val_i,
  input  logic          ins_en_i,
  input  logic          drn_en_i,
  output logic          ge_o,
  output logic [W-1:0]  slot_o
);
  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  // Occupied slots that are >= the new word stay put, so equal values keep arrival order.
  assign ge_o   = (CW'(IDX) < cnt_i) && (slot_q >= in_data_i);
  assign slot_o = slot_q;

  // The first non-ge slot takes the new word; every slot below it takes its upper neighbor.
  always_comb begin
    slot_d = slot_q;
    if (ins_en_i) begin
      if (!ge_o) begin
        slot_d = ge_up_i ? in_data_i : up_val_i;
      end
    end else if (drn_en_i) begin
      slot_d = dn_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end
endmodule

// File: rtl/sort6_stream.sv
// rtl/sort6_stream.sv - serial-in, largest-first serial-out N-word burst sorter
module sort6_stream
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);
  localparam int CW = $clog2(N + 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ge   [N];
  logic [W-1:0]  slot [N];
  logic          in_fire;
  logic          out_fire;

  assign in_ready  = rst_n && (state_q == LOAD);
  assign out_valid = rst_n && (state_q == DRAIN);
  assign out_last  = out_valid && (cnt_q == CW'(1));
  assign out_data  = out_valid ? slot[0] : '0;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_ready && out_valid;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic         ge_up;
    logic [W-1:0] up_val;
    logic [W-1:0] dn_val;

    if (i == 0) begin : g_top
      assign ge_up  = 1'b1;
      assign up_val = '0;
    end else begin : g_mid
      assign ge_up  = ge[i-1];
      assign up_val = slot[i-1];
    end

    if (i == N - 1) begin : g_bot
      assign dn_val = '0;
    end else begin : g_up
      assign dn_val = slot[i+1];
    end

    sort_cell #(.W(W), .CW(CW), .IDX(i)) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data_i (in_data),
      .cnt_i     (cnt_q),
      .ge_up_i   (ge_up),
      .up_val_i  (up_val),
      .dn_val_i  (dn_val),
      .ins_en_i  (in_fire),
      .drn_en_i  (out_fire),
      .ge_o      (ge[i]),
      .slot_o    (slot[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sort6_stream.sv
// tb/tb_sort6_stream.sv - randomized self-checking bench for sort6_stream
module tb_sort6_stream;
  typedef logic [7:0] burst_t [6];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sort6_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  function automatic burst_t sort_desc(input burst_t b);
    burst_t r = b;
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (r[j] > r[i]) begin
          logic [7:0] t = r[i];
          r[i] = r[j];
          r[j] = t;
        end
    return r;
  endfunction

  // Feeds one burst and drains it; stall is the percent chance of idling each side.
  task automatic run_burst(input string name, input burst_t d, input int stall);
    burst_t     exp = sort_desc(d);
    int         sent = 0;
    int         got = 0;
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    bit         v;
    for (int cyc = 0; cyc < 400 && got < 6; cyc++) begin
      @(negedge clk);
      if (sent < 6) begin
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s load_handshake: in_ready=%b out_valid=%b, want 1/0", name, in_ready, out_valid);
        end
        v         = (stall == 0) || ($urandom_range(0, 99) >= stall);
        in_valid  = v;
        in_data   = v ? d[sent] : 8'($urandom);
        out_ready = 1'($urandom);
        if (v && in_ready === 1'b1) sent++;
      end else begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp[got]
            || out_last !== (got == 5)) begin
          n_fail++;
          $display("FAIL %s drain_word%0d: valid=%b ready=%b data=%0d last=%b, want 1/0/%0d/%b",
                   name, got, out_valid, in_ready, out_data, out_last, exp[got], (got == 5));
        end
        if (prev_hold) begin
          n_checks++;
          if (out_data !== prev_data || out_last !== prev_last) begin
            n_fail++;
            $display("FAIL %s hold_stable: data=%0d last=%b, want %0d/%b",
                     name, out_data, out_last, prev_data, prev_last);
          end
        end
        out_ready = (stall == 0) || ($urandom_range(0, 99) >= stall);
        in_valid  = 1'($urandom);
        in_data   = 8'($urandom);
        prev_hold = !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (out_ready && out_valid === 1'b1) got++;
      end
    end
    n_checks++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d words, want 6", name, got);
    end
  endtask

  task automatic check_gated(input string name);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL %s gated: in_ready=%b out_valid=%b out_last=%b out_data=%0d, want 0/0/0/0",
               name, in_ready, out_valid, out_last, out_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    check_gated("reset");
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    run_burst("basic", '{8'd12, 8'd200, 8'd7, 8'd255, 8'd0, 8'd99}, 0);
  endtask

  task automatic test_duplicates();
    run_burst("dups", '{8'd5, 8'd9, 8'd5, 8'd9, 8'd5, 8'd9}, 0);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_zero", '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0);
    run_burst("b2b_full", '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 0);
  endtask

  task automatic test_sorted_orders();
    run_burst("ascending", '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, 0);
    run_burst("descending", '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0);
  endtask

  task automatic test_random();
    burst_t b;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 6; i++)
        b[i] = (n % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_burst("random", b, 35);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] early [3] = '{8'd200, 8'd150, 8'd100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0; in_data = early[i];
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_gated("mid_load_reset");
    rst_n = 1'b1;
    run_burst("after_reset", '{8'd3, 8'd1, 8'd2, 8'd8, 8'd4, 8'd6}, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicates();
    test_back_to_back();
    test_sorted_orders();
    test_random();
    test_reset_mid_load();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
